srv6_encap: RTL and testbench
=============================

Name: srv6_encap

Overview:
- SRv6 headend (H.Insert) for the 512-bit beat datapath. It is the source-side counterpart of the srv6 endpoint block.
- Takes a plain IPv6 packet, inserts a Segment Routing Header (SRH) carrying 1..3 segments, and rewrites the IPv6 fields. It then re-aligns the payload to the new header length and streams the result on the same beat interface the endpoint consumes.

Parameters:
- ROUTING_TYPE, 4, value written to SRH routing_type.
- SRH_TAG, 16'h0000, value written to SRH tag.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- din  in  512  input beat; byte 0 at din[511:504].
- valid  in  1  din is valid this cycle. Must be held low while ready=0.
- ready  out  1  block accepts a beat this cycle.
- encap_en  in  1  insertion enable, sampled on the header beat.
- seg_num  in  2  total segment entries N (1..3), sampled on the header beat.
- seg_list  in  256  [255:128]=SL[1], [127:0]=SL[2], sampled on the header beat.
- dout  out  512  output beat.
- we  out  1  dout valid.

Behaviour:
- **Reset** (reset=0 at a clock edge): dout=0, we=0, ready=1, state=IDLE. Any in-flight packet is discarded. Reset overrides all other activity.
- **Input framing**
  - The first accepted beat is the header beat: bytes 0..39 are the IPv6 header, bytes 40..63 are payload.
  - PL = din[479:464].
  - Input beats per packet = ceil((40+PL)/64).
  - Bytes beyond 40+PL in the last beat are ignored.
  - valid may drop between beats; nothing is emitted during gaps.
- **Bypass** applies if encap_en=0, next_header==43, seg_num==0, or PL+8+16N > 65535.
  - Every input beat is reproduced unchanged on dout with we=1 exactly one cycle after acceptance.
  - ready stays 1.
- **Encapsulated output stream**, with N = seg_num, SL[0] = original DA:
  - Bytes 0..39: IPv6 header with:
    - version, traffic_class, flow_label, hop_limit, SA unchanged;
    - payload_length = PL+8+16N;
    - next_header = 43;
    - DA = SL[N-1].
  - Bytes 40..47: the SRH fixed part:
    - next_header = original next_header;
    - hdr_ext_len = 2N;
    - routing_type = ROUTING_TYPE;
    - segments_left = N-1;
    - last_entry = N-1;
    - flags = 0;
    - tag = SRH_TAG.
  - Bytes 48..48+16N-1: SL[0], SL[1], .. SL[N-1] in that order.
  - Then PL payload bytes, in original order.
  - Output beats = ceil((48+16N+PL)/64). Bytes past the packet end in the last beat are 0.
- **Timing**
  - The shift S = 8+16N is < 64, so output beat k is completed by input beat k.
  - Output beat k is emitted with we=1 in the cycle after input beat k is accepted.
  - If output beats exceed input beats (at most +1), the tail beat is emitted in the cycle after the last input beat. ready=0 during the cycle that beat is pending, i.e. the cycle after the last input beat is accepted.
  - At most one output beat per cycle.
- **States**
  - IDLE: ready=1. On valid, latch fields and residue bytes. Go to BYPASS or DATA; if the packet is one beat, go to TAIL or IDLE as appropriate.
  - DATA: consume beats and emit re-aligned beats. After the last input beat, go to TAIL if an extra beat is needed, else IDLE.
  - TAIL: ready=0, emit the final beat, go to IDLE.
  - BYPASS: pass beats through; return to IDLE after the last input beat.
- **Back-to-back packets:** a new header beat is accepted in the cycle the previous packet's last output beat is emitted, provided ready=1.
- Arithmetic is unsigned 16-bit.

Test Plan:
1. **N=1, PL=24, single input beat at cycle t, orig DA=A.**
   - ready=0 at t+1; beats at t+1 and t+2.
   - Beat0: payload_length=48, next_header=43, DA=A, hdr_ext_len=2, segments_left=0, last_entry=0, bytes 48..63=A.
   - Beat1: bytes 0..23 = payload, bytes 24..63 = 0.
2. **N=3, PL=88, 2 input beats, SL[1]=B, SL[2]=C.**
   - 3 output beats: DA=C, payload_length=144, hdr_ext_len=6, segments_left=2.
   - SL order A, B, C at bytes 48, 64, 80.
   - Payload byte 0 at output byte 96.
   - Tail beat emitted with ready=0.
3. **N=2, PL=152, 3 input beats with a 2-cycle gap before beat 2.**
   - 4 output beats; we low during the gap.
   - Output beat 2 appears exactly 1 cycle after input beat 2.
   - Payload re-aligned by 40 bytes.
4. **Bypass (next_header=43; separately encap_en=0; separately seg_num=0).**
   - dout equals din delayed 1 cycle; we mirrors valid; ready stays 1.
5. **Two back-to-back N=1, PL=24 packets.**
   - Second header is held off by ready=0 for one cycle, then processed correctly.
   - Output beats are contiguous with no corruption.
6. **Assert reset for one cycle mid-packet (after input beat 1 of 3).**
   - Next cycle: we=0, dout=0, ready=1.
   - A fresh packet after reset is encapsulated correctly.

Source files
------------

// File: rtl/srv6_encap.sv
// SRv6 headend (H.Insert): inserts an SRH with 1..3 segments into an IPv6 packet
// carried on a 512-bit beat stream and re-aligns the payload behind it.
module srv6_encap #(
    parameter int unsigned ROUTING_TYPE = 4,
    parameter logic [15:0] SRH_TAG      = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [511:0] din,
    input  logic         valid,
    output logic         ready,
    input  logic         encap_en,
    input  logic [1:0]   seg_num,
    input  logic [255:0] seg_list,
    output logic [511:0] dout,
    output logic         we
);

    // state  | meaning
    // IDLE   | waiting for a header beat
    // DATA   | consuming payload beats, emitting re-aligned beats
    // TAIL   | emitting the extra final beat, input stalled
    // BYPASS | passing a packet through unchanged
    typedef enum logic [1:0] {IDLE, DATA, TAIL, BYPASS} state_t;

    localparam logic [7:0] RT = 8'(ROUTING_TYPE);

    state_t         state_q, state_d;
    logic [511:0]   dout_q, dout_d;
    logic           we_q, we_d;
    logic [511:0]   prev_q, prev_d;
    logic [10:0]    k_q, k_d;
    logic [16:0]    in_len_q, in_len_d;
    logic [16:0]    out_len_q, out_len_d;
    logic [1:0]     n_q, n_d;

    logic [15:0]    pl;
    logic [7:0]     nh;
    logic [16:0]    new_pl, hdr_in_len, hdr_out_len;
    logic           do_bypass;
    logic [127:0]   sl_last;
    logic [511:0]   beat0, resid, cur, mask, realigned;
    logic [5:0]     off;
    logic [9:0]     sh;
    logic [16:0]    rem, beat_end;

    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        we_d      = 1'b0;
        prev_d    = prev_q;
        k_d       = k_q;
        in_len_d  = in_len_q;
        out_len_d = out_len_q;
        n_d       = n_q;

        pl          = din[479:464];
        nh          = din[463:456];
        new_pl      = {1'b0, pl} + 17'd8 + {11'd0, seg_num, 4'd0};
        hdr_in_len  = {1'b0, pl} + 17'd40;
        hdr_out_len = new_pl + 17'd40;
        do_bypass   = !encap_en || (nh == 8'd43) || (seg_num == 2'd0) || new_pl[16];

        case (seg_num)
            2'd2:    sl_last = seg_list[255:128];
            2'd3:    sl_last = seg_list[127:0];
            default: sl_last = din[319:192];
        endcase

        beat0 = {din[511:480], new_pl[15:0], 8'd43, din[455:320], sl_last,
                 nh, {5'd0, seg_num, 1'b0}, RT, {6'd0, seg_num - 2'd1},
                 {6'd0, seg_num - 2'd1}, 8'd0, SRH_TAG, din[319:192]};

        // Synthetic previous beat: SL[1..N-1] sit just ahead of the payload so that
        // the generic shift window places them at output bytes 64.. of beat 1.
        resid = {64'd0, seg_list[255:128],
                 (seg_num == 2'd3) ? seg_list[127:0] : seg_list[255:128],
                 din[191:0]};

        off       = 6'd56 - {n_q, 4'd0};
        sh        = {1'b0, off, 3'd0};
        cur       = (state_q == TAIL) ? '0 : din;
        rem       = out_len_q - {k_q, 6'd0};
        mask      = (rem < 17'd64) ? ~({512{1'b1}} >> {rem[5:0], 3'd0}) : {512{1'b1}};
        realigned = ((prev_q << sh) | (cur >> (10'd512 - sh))) & mask;
        beat_end  = {k_q + 11'd1, 6'd0};

        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    we_d      = 1'b1;
                    k_d       = 11'd1;
                    in_len_d  = hdr_in_len;
                    out_len_d = hdr_out_len;
                    n_d       = seg_num;
                    if (do_bypass) begin
                        dout_d  = din;
                        state_d = (hdr_in_len > 17'd64) ? BYPASS : IDLE;
                    end else begin
                        dout_d = beat0;
                        prev_d = resid;
                        if (hdr_in_len > 17'd64)
                            state_d = DATA;
                        else if (hdr_out_len > 17'd64)
                            state_d = TAIL;
                        else
                            state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (valid) begin
                    we_d   = 1'b1;
                    dout_d = realigned;
                    prev_d = din;
                    k_d    = k_q + 11'd1;
                    if (beat_end >= in_len_q)
                        state_d = (beat_end < out_len_q) ? TAIL : IDLE;
                end
            end
            TAIL: begin
                we_d    = 1'b1;
                dout_d  = realigned;
                state_d = IDLE;
            end
            BYPASS: begin
                if (valid) begin
                    we_d   = 1'b1;
                    dout_d = din;
                    k_d    = k_q + 11'd1;
                    if (beat_end >= in_len_q)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            dout_q    <= '0;
            we_q      <= 1'b0;
            prev_q    <= '0;
            k_q       <= '0;
            in_len_q  <= '0;
            out_len_q <= '0;
            n_q       <= '0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            we_q      <= we_d;
            prev_q    <= prev_d;
            k_q       <= k_d;
            in_len_q  <= in_len_d;
            out_len_q <= out_len_d;
            n_q       <= n_d;
        end
    end

    assign ready = (state_q != TAIL);
    assign dout  = dout_q;
    assign we    = we_q;

endmodule

// File: tb/tb_srv6_encap.sv
// Scoreboard bench for srv6_encap: a byte-level packet model predicts every
// output beat and the cycle it must appear in.
module tb_srv6_encap;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] din;
    logic         valid;
    logic         ready;
    logic         encap_en;
    logic [1:0]   seg_num;
    logic [255:0] seg_list;
    logic [511:0] dout;
    logic         we;

    srv6_encap dut (
        .clk(clk), .reset(reset), .din(din), .valid(valid), .ready(ready),
        .encap_en(encap_en), .seg_num(seg_num), .seg_list(seg_list),
        .dout(dout), .we(we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [511:0] data;
        int           cyc;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;

    logic [7:0] in_b[$];
    logic [7:0] out_b[$];
    logic [7:0] sl_b[32];

    always @(negedge clk) begin
        if (we === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat cyc=%0d got=%h", cyc, dout);
            end else begin
                mon_e = expq.pop_front();
                if (dout !== mon_e.data || cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL beat cyc=%0d exp_cyc=%0d got=%h exp=%h", cyc, mon_e.cyc, dout, mon_e.data);
                end
            end
        end
    end

    function automatic logic [7:0] segb(input int s, input int j);
        if (s == 0) return in_b[24 + j];
        else if (s == 1) return sl_b[j];
        else return sl_b[16 + j];
    endfunction

    function automatic logic [511:0] beat_of(input bit sel, input int k);
        logic [511:0] r;
        int idx;
        for (int j = 0; j < 64; j++) begin
            idx = 64 * k + j;
            if (!sel) r[511 - 8*j -: 8] = (idx < in_b.size()) ? in_b[idx] : 8'($urandom);
            else      r[511 - 8*j -: 8] = (idx < out_b.size()) ? out_b[idx] : 8'd0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, expv);
        end
    endtask

    // gap_beat/gap_len force a gap before one beat; abort_after>0 resets the DUT
    // once that many input beats have been accepted.
    task automatic send_pkt(input int n, input int pl, input bit en, input logic [7:0] nh,
                            input int max_gap, input int gap_beat, input int gap_len,
                            input int abort_after);
        logic [255:0] sl;
        logic [511:0] ib[$];
        int in_beats, out_beats, new_pl, gap, tries;
        bit byp;
        exp_t e;

        in_b.delete();
        out_b.delete();
        for (int i = 0; i < 40; i++) in_b.push_back(8'($urandom));
        in_b[4] = 8'(pl >> 8);
        in_b[5] = 8'(pl);
        in_b[6] = nh;
        for (int i = 0; i < pl; i++) in_b.push_back(8'($urandom));
        for (int i = 0; i < 32; i++) begin
            sl_b[i] = 8'($urandom);
            sl[255 - 8*i -: 8] = sl_b[i];
        end

        new_pl = pl + 8 + 16 * n;
        byp = !en || (nh == 8'd43) || (n == 0) || (new_pl > 65535);
        if (!byp) begin
            for (int i = 0; i < 4; i++) out_b.push_back(in_b[i]);
            out_b.push_back(8'(new_pl >> 8));
            out_b.push_back(8'(new_pl));
            out_b.push_back(8'd43);
            out_b.push_back(in_b[7]);
            for (int i = 8; i < 24; i++) out_b.push_back(in_b[i]);
            for (int j = 0; j < 16; j++) out_b.push_back(segb(n - 1, j));
            out_b.push_back(nh);
            out_b.push_back(8'(2 * n));
            out_b.push_back(8'd4);
            out_b.push_back(8'(n - 1));
            out_b.push_back(8'(n - 1));
            out_b.push_back(8'd0);
            out_b.push_back(8'd0);
            out_b.push_back(8'd0);
            for (int s = 0; s < n; s++)
                for (int j = 0; j < 16; j++) out_b.push_back(segb(s, j));
            for (int i = 0; i < pl; i++) out_b.push_back(in_b[40 + i]);
        end

        in_beats  = (40 + pl + 63) / 64;
        out_beats = byp ? in_beats : (out_b.size() + 63) / 64;
        for (int k = 0; k < in_beats; k++) ib.push_back(beat_of(1'b0, k));

        for (int k = 0; k < in_beats; k++) begin
            if (abort_after > 0 && k == abort_after) begin
                valid = 1'b0;
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                chk("reset_we", {511'd0, we}, 512'd0);
                chk("reset_dout", dout, 512'd0);
                chk("reset_ready", {511'd0, ready}, 512'd1);
                return;
            end
            gap = 0;
            if (k > 0) gap = (k == gap_beat) ? gap_len : $urandom_range(max_gap, 0);
            repeat (gap) begin
                valid = 1'b0;
                din = {16{$urandom}};
                @(negedge clk);
            end
            tries = 0;
            while (!ready && tries < 4) begin
                valid = 1'b0;
                @(negedge clk);
                tries++;
            end
            if (!ready) begin
                checks++;
                failures++;
                $display("FAIL ready_stuck got=%0b exp=1", ready);
            end
            valid    = 1'b1;
            din      = ib[k];
            encap_en = (k == 0) ? en : 1'($urandom);
            seg_num  = (k == 0) ? 2'(n) : 2'($urandom);
            seg_list = (k == 0) ? sl : {8{$urandom}};
            e.data = byp ? ib[k] : beat_of(1'b1, k);
            e.cyc  = cyc + 1;
            expq.push_back(e);
            @(negedge clk);
        end
        valid = 1'b0;
        if (!byp && out_beats > in_beats) begin
            e.data = beat_of(1'b1, in_beats);
            e.cyc  = cyc + 1;
            expq.push_back(e);
        end
        chk("ready_after_last", {511'd0, ready}, {511'd0, !(!byp && out_beats > in_beats)});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        valid    = 1'b0;
        din      = '0;
        encap_en = 1'b0;
        seg_num  = 2'd0;
        seg_list = '0;
        repeat (3) @(negedge clk);
        chk("init_we", {511'd0, we}, 512'd0);
        chk("init_dout", dout, 512'd0);
        chk("init_ready", {511'd0, ready}, 512'd1);
        reset = 1'b1;
        @(negedge clk);

        send_pkt(1, 24, 1'b1, 8'd17, 0, -1, 0, 0);
        send_pkt(3, 88, 1'b1, 8'd6, 0, -1, 0, 0);
        send_pkt(2, 152, 1'b1, 8'd17, 0, 2, 2, 0);
        send_pkt(2, 100, 1'b1, 8'd43, 1, -1, 0, 0);
        send_pkt(2, 100, 1'b0, 8'd17, 1, -1, 0, 0);
        send_pkt(0, 100, 1'b1, 8'd17, 1, -1, 0, 0);
        send_pkt(1, 24, 1'b1, 8'd59, 0, -1, 0, 0);
        send_pkt(1, 24, 1'b1, 8'd59, 0, -1, 0, 0);
        send_pkt(2, 150, 1'b1, 8'd17, 0, -1, 0, 1);
        send_pkt(2, 50, 1'b1, 8'd17, 0, -1, 0, 0);
        send_pkt(1, 0, 1'b1, 8'd17, 0, -1, 0, 0);
        send_pkt(3, 0, 1'b1, 8'd17, 0, -1, 0, 0);
        send_pkt(1, 65511, 1'b1, 8'd17, 0, -1, 0, 0);
        send_pkt(1, 65512, 1'b1, 8'd17, 0, -1, 0, 0);
        repeat (30) begin
            send_pkt($urandom_range(3, 0), $urandom_range(300, 0), ($urandom % 5) != 0,
                     (($urandom % 5) == 0) ? 8'd43 : 8'($urandom), 2, -1, 0, 0);
        end

        repeat (6) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL missing_beats got=%0d exp=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
